// File: rtl/addsub_nbit_seq_if.sv
// Operand/result bundle for the chunked sequential adder/subtractor.
// The requester drives start and the operands and receives the registered result and status.
interface addsub_nbit_seq_if #(
    parameter int SIZE = 8
);
    logic            start;
    logic            mode;
    logic [SIZE-1:0] a;
    logic [SIZE-1:0] b;
    logic            cin;
    logic [SIZE-1:0] s;
    logic            cout;
    logic            ovf;
    logic            busy;
    logic            done;

    modport master (
        output start, mode, a, b, cin,
        input  s, cout, ovf, busy, done
    );

    modport slave (
        input  start, mode, a, b, cin,
        output s, cout, ovf, busy, done
    );
endinterface

// File: rtl/addsub_nbit_seq.sv
// Multi-cycle adder/subtractor: adds a SIZE-bit operand pair CHUNK bits per clock, LSB chunk first,
// with a 1-bit carry register between chunks and a start/busy/done handshake.
module addsub_nbit_seq #(
    parameter int SIZE  = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    addsub_nbit_seq_if.slave bus
);
    localparam int NCHUNK = SIZE / CHUNK;
    localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state;
    state_t          nextState;
    logic [SIZE-1:0] opA;
    logic [SIZE-1:0] opB;
    logic [SIZE-1:0] work;
    logic [SIZE-1:0] nextWork;
    logic            carry;
    logic [KW-1:0]   k;
    logic [CHUNK-1:0] chunkA;
    logic [CHUNK-1:0] chunkB;
    logic [CHUNK:0]  chunkSum;
    logic            msbCarryIn;
    logic            lastChunk;

    assign lastChunk = (k == KW'(NCHUNK - 1));

    // One chunk-wide ripple; the carry into the top bit is recovered from the top sum bit.
    always_comb begin
        chunkA     = opA[int'(k) * CHUNK +: CHUNK];
        chunkB     = opB[int'(k) * CHUNK +: CHUNK];
        chunkSum   = {1'b0, chunkA} + {1'b0, chunkB} + {{CHUNK{1'b0}}, carry};
        msbCarryIn = chunkSum[CHUNK-1] ^ chunkA[CHUNK-1] ^ chunkB[CHUNK-1];
        nextWork   = work;
        nextWork[int'(k) * CHUNK +: CHUNK] = chunkSum[CHUNK-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (bus.start) nextState = RUN;
            RUN:     if (lastChunk) nextState = DONE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state != IDLE);
        bus.done = (state == DONE);
    end

    // Subtraction is folded into capture: B is inverted and the carry seeded with 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opA      <= '0;
            opB      <= '0;
            work     <= '0;
            carry    <= 1'b0;
            k        <= '0;
            bus.s    <= '0;
            bus.cout <= 1'b0;
            bus.ovf  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        opA   <= bus.a;
                        opB   <= bus.mode ? ~bus.b : bus.b;
                        carry <= bus.mode ? 1'b1 : bus.cin;
                        work  <= '0;
                        k     <= '0;
                    end
                end
                RUN: begin
                    work  <= nextWork;
                    carry <= chunkSum[CHUNK];
                    k     <= k + KW'(1);
                    if (lastChunk) begin
                        bus.s    <= nextWork;
                        bus.cout <= chunkSum[CHUNK];
                        bus.ovf  <= msbCarryIn ^ chunkSum[CHUNK];
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_addsub_nbit_seq.sv
// Scoreboard bench for addsub_nbit_seq at CHUNK = 2, 8 and 1 (SIZE = 8).
// Stimulus pushes expected results; per-instance monitors pop and compare on each done pulse.
module tb_addsub_nbit_seq;
    typedef struct {
        logic [7:0] s;
        logic       cout;
        logic       ovf;
        int         doneCyc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    exp_t q2[$];
    exp_t q8[$];
    exp_t q1[$];
    exp_t e2;
    exp_t e8;
    exp_t e1;

    addsub_nbit_seq_if #(.SIZE(8)) if2 ();
    addsub_nbit_seq_if #(.SIZE(8)) if8 ();
    addsub_nbit_seq_if #(.SIZE(8)) if1 ();

    addsub_nbit_seq #(.SIZE(8), .CHUNK(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));
    addsub_nbit_seq #(.SIZE(8), .CHUNK(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
    addsub_nbit_seq #(.SIZE(8), .CHUNK(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s got %h expected %h at cycle %0d", name, act, req, cyc);
        end
    endtask

    function automatic int nChunk(input int which);
        return (which == 2) ? 4 : ((which == 8) ? 1 : 8);
    endfunction

    // Each monitor compares result and completion cycle; a done with nothing queued is an error.
    always @(negedge clk) begin
        if (if2.done) begin
            if (q2.size() == 0) checkOutput("spurious done c2", 32'(1), 32'(0));
            else begin
                e2 = q2.pop_front();
                checkOutput("result c2", {if2.s, if2.cout, if2.ovf}, {e2.s, e2.cout, e2.ovf});
                checkOutput("done cycle c2", cyc, e2.doneCyc);
            end
        end
    end

    always @(negedge clk) begin
        if (if8.done) begin
            if (q8.size() == 0) checkOutput("spurious done c8", 32'(1), 32'(0));
            else begin
                e8 = q8.pop_front();
                checkOutput("result c8", {if8.s, if8.cout, if8.ovf}, {e8.s, e8.cout, e8.ovf});
                checkOutput("done cycle c8", cyc, e8.doneCyc);
            end
        end
    end

    always @(negedge clk) begin
        if (if1.done) begin
            if (q1.size() == 0) checkOutput("spurious done c1", 32'(1), 32'(0));
            else begin
                e1 = q1.pop_front();
                checkOutput("result c1", {if1.s, if1.cout, if1.ovf}, {e1.s, e1.cout, e1.ovf});
                checkOutput("done cycle c1", cyc, e1.doneCyc);
            end
        end
    end

    task automatic setInputs(input bit rnd);
        if2.start = rnd ? 1'($urandom) : 1'b0;  if2.mode = rnd ? 1'($urandom) : 1'b0;
        if2.a = rnd ? 8'($urandom) : 8'h0;      if2.b = rnd ? 8'($urandom) : 8'h0;
        if2.cin = rnd ? 1'($urandom) : 1'b0;
        if8.start = rnd ? 1'($urandom) : 1'b0;  if8.mode = rnd ? 1'($urandom) : 1'b0;
        if8.a = rnd ? 8'($urandom) : 8'h0;      if8.b = rnd ? 8'($urandom) : 8'h0;
        if8.cin = rnd ? 1'($urandom) : 1'b0;
        if1.start = rnd ? 1'($urandom) : 1'b0;  if1.mode = rnd ? 1'($urandom) : 1'b0;
        if1.a = rnd ? 8'($urandom) : 8'h0;      if1.b = rnd ? 8'($urandom) : 8'h0;
        if1.cin = rnd ? 1'($urandom) : 1'b0;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " c2"}, 32'({if2.s, if2.cout, if2.ovf, if2.busy, if2.done}), 32'(0));
        checkOutput({tag, " c8"}, 32'({if8.s, if8.cout, if8.ovf, if8.busy, if8.done}), 32'(0));
        checkOutput({tag, " c1"}, 32'({if1.s, if1.cout, if1.ovf, if1.busy, if1.done}), 32'(0));
    endtask

    // Called at a negedge; start is held for exactly one rising edge.
    task automatic applyStimulus(input int which, input logic mode, input logic [7:0] a,
                                 input logic [7:0] b, input logic cin, input logic [7:0] es,
                                 input logic ec, input logic eo);
        exp_t e;
        e = '{es, ec, eo, cyc + 1 + nChunk(which)};
        case (which)
            2: begin if2.start = 1'b1; if2.mode = mode; if2.a = a; if2.b = b; if2.cin = cin; q2.push_back(e); end
            8: begin if8.start = 1'b1; if8.mode = mode; if8.a = a; if8.b = b; if8.cin = cin; q8.push_back(e); end
            default: begin if1.start = 1'b1; if1.mode = mode; if1.a = a; if1.b = b; if1.cin = cin; q1.push_back(e); end
        endcase
        @(negedge clk);
        if2.start = 1'b0;
        if8.start = 1'b0;
        if1.start = 1'b0;
    endtask

    task automatic waitIdle(input int maxCyc);
        for (int i = 0; i < maxCyc; i++) begin
            if (q2.size() == 0 && q8.size() == 0 && q1.size() == 0) break;
            @(negedge clk);
        end
        if (q2.size() != 0 || q8.size() != 0 || q1.size() != 0) begin
            checkOutput("timeout waiting for done", 32'(q2.size() + q8.size() + q1.size()), 32'(0));
            q2.delete();
            q8.delete();
            q1.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] bEff;
        logic       mode;
        logic       cin;
        logic [8:0] r;

        rst_n = 1'b1;
        setInputs(1'b0);
        #1 rst_n = 1'b0;
        setInputs(1'b1);
        @(negedge clk);
        checkAllZero("reset held");
        setInputs(1'b1);
        @(negedge clk);
        checkAllZero("reset held random");
        setInputs(1'b0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checkAllZero("idle after release");

        // Add with busy window: start edge t, busy for 5 cycles, done at t+4.
        applyStimulus(2, 1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            checkOutput("busy during op c2", 32'(if2.busy), 32'(1));
            @(negedge clk);
        end
        checkOutput("busy after op c2", 32'(if2.busy), 32'(0));
        waitIdle(20);

        applyStimulus(2, 1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);  waitIdle(20);
        applyStimulus(2, 1'b0, 8'h10, 8'h20, 1'b1, 8'h31, 1'b0, 1'b0);  waitIdle(20);
        applyStimulus(2, 1'b1, 8'h05, 8'h07, 1'b0, 8'hFE, 1'b0, 1'b0);  waitIdle(20);
        applyStimulus(2, 1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1);  waitIdle(20);
        applyStimulus(2, 1'b1, 8'h07, 8'h07, 1'b0, 8'h00, 1'b1, 1'b0);  waitIdle(20);

        // Scramble inputs and pulse start through RUN and DONE; only the captured op may complete.
        applyStimulus(2, 1'b0, 8'h3C, 8'h45, 1'b0, 8'h81, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            if2.start = 1'b1;
            if2.mode = 1'b1;
            if2.a = 8'($urandom);
            if2.b = 8'($urandom);
            if2.cin = 1'($urandom);
            @(negedge clk);
        end
        if2.start = 1'b0;
        repeat (6) @(negedge clk);
        waitIdle(20);
        repeat (3) @(negedge clk);
        checkOutput("hold after done c2", 32'({if2.s, if2.cout, if2.ovf, if2.busy}), 32'({8'h81, 1'b0, 1'b1, 1'b0}));

        // Abort in the second RUN cycle.
        applyStimulus(2, 1'b0, 8'h11, 8'h22, 1'b0, 8'h33, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        q2.delete();
        #1;
        checkAllZero("mid-run reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        checkAllZero("after aborted op");
        applyStimulus(2, 1'b0, 8'h03, 8'h04, 1'b0, 8'h07, 1'b0, 1'b0);  waitIdle(20);

        applyStimulus(8, 1'b0, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);  waitIdle(20);
        applyStimulus(1, 1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);  waitIdle(20);

        // CHUNK = 1 sweep against a whole-word reference.
        for (int n = 0; n < 1000; n++) begin
            mode = 1'($urandom);
            a    = 8'($urandom);
            b    = 8'($urandom);
            cin  = 1'($urandom);
            bEff = mode ? ~b : b;
            r    = {1'b0, a} + {1'b0, bEff} + {8'h00, (mode ? 1'b1 : cin)};
            applyStimulus(1, mode, a, b, cin, r[7:0], r[8], (a[7] == bEff[7]) && (r[7] != a[7]));
            waitIdle(20);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/addsub_nbit_seq.md
# addsub_nbit_seq

Parametrised multi-cycle adder/subtractor that processes a SIZE-bit operand pair CHUNK bits per clock, LSB chunk first, carrying between chunks in a register. It extends the team's combinational n-bit ripple-carry adder with several new features: add/subtract mode, signed-overflow detection, operand capture and a start/busy/done handshake. It trades latency for a short carry chain and sits in datapaths that need a registered arithmetic result at a configurable area/speed point.

## Interface
- SIZE, 8, operand/result width in bits; must be an integer multiple of CHUNK.
- CHUNK, 2, bits added per clock; 1 ≤ CHUNK ≤ SIZE. NCHUNK = SIZE/CHUNK (derived).

Ports:
- PortClk  input  1  system clock, rising-edge active.
- PortRst_n  input  1  asynchronous, active-low reset.
- PortStart  input  1  start request; sampled only in IDLE.
- PortMode  input  1  0 = A + B + Cin; 1 = A − B (A + ~B + 1).
- PortA  input  SIZE  operand A (unsigned or two's complement).
- PortB  input  SIZE  operand B.
- PortCin  input  1  carry-in for add mode; ignored when PortMode=1.
- PortS  output  SIZE  registered result.
- PortCout  output  1  final carry-out. In subtract mode this is the no-borrow flag: 1 when A ≥ B unsigned.
- PortOvf  output  1  signed overflow: carry into MSB XOR carry out of MSB.
- PortBusy  output  1  high in RUN and DONE.
- PortDone  output  1  one-cycle pulse; result valid.

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE**
  - When PortStart=1 at an edge, capture PortA into opA and B_eff into opB, where B_eff = PortB (add) or ~PortB (sub).
  - Load carry = PortCin (add) or 1 (sub). Clear chunk index k = 0. Go to RUN.
- **RUN**
  - Each edge adds opA[k·CHUNK +: CHUNK] + opB[same] + carry.
  - Write the CHUNK-bit sum into the working register and update carry; k increments.
  - On the edge that processes k = NCHUNK−1:
    - copy the working register to PortS;
    - copy the final carry to PortCout;
    - set PortOvf = (carry into bit SIZE−1) XOR (carry out of bit SIZE−1);
    - go to DONE.
- **DONE**
  - PortDone=1 for exactly one cycle, then return to IDLE unconditionally.
- Arithmetic is modulo 2^SIZE. The carry register is 1 bit. The carry into the MSB is taken from inside the final chunk's adder (for CHUNK=1, it is the carry register value).
- PortS, PortCout and PortOvf change only on the DONE-entry edge. They hold their values through IDLE until the next completion; partial sums are never visible.
- PortStart in RUN or DONE is ignored and not queued.
- Operand, mode and Cin changes after capture have no effect on the current operation.
- Reset asserted at any time (including mid-RUN):
  - aborts immediately; state = IDLE;
  - all outputs 0 (PortS=0, PortCout=0, PortOvf=0, PortBusy=0, PortDone=0);
  - working and operand registers cleared; no PortDone is produced for the aborted operation.
- CHUNK = SIZE (NCHUNK = 1) is legal: a single RUN cycle.

## Timing
- Start is sampled at edge t (in IDLE). RUN occupies edges t+1 … t+NCHUNK.
- The result registers update at edge t+NCHUNK.
- PortDone is high during the cycle between edges t+NCHUNK and t+NCHUNK+1.
- Latency from start edge to PortDone rise is NCHUNK edges. Throughput is one operation per NCHUNK+2 cycles (start edge in IDLE + NCHUNK RUN + 1 DONE).
- PortBusy rises at edge t+1 and falls at edge t+NCHUNK+1. A new start may be sampled at edge t+NCHUNK+2 or later.
- All outputs are registered; there are no combinational input-to-output paths.
- Critical path is one CHUNK-bit ripple plus the carry register.

## Test plan
- **Reset:** hold PortRst_n=0 with random inputs -> all outputs 0. Release, no start -> outputs stay 0 and PortBusy=0.
- **Add, SIZE=8, CHUNK=2:**
  - 0xFF + 0x01, Cin=0 -> PortS=0x00, Cout=1, Ovf=0. PortDone high exactly 4 edges after the start edge; PortBusy high for 5 cycles.
  - 0x7F + 0x01 -> 0x80, Cout=0, Ovf=1.
  - 0x10 + 0x20, Cin=1 -> 0x31.
- **Subtract:**
  - 0x05 − 0x07 -> 0xFE, Cout=0, Ovf=0.
  - 0x80 − 0x01 -> 0x7F, Cout=1, Ovf=1.
  - 0x07 − 0x07 with Cin=0 -> 0x00, Cout=1 (Cin ignored).
- **Ignore rules:**
  - Change PortA/PortB/PortMode and pulse PortStart during RUN and DONE -> result equals the captured operation, and only one PortDone occurs.
  - Outputs hold their value afterward until the next DONE.
- **Mid-operation reset:** assert PortRst_n=0 at the 2nd RUN cycle -> outputs 0 immediately with no PortDone. After release, start 0x03 + 0x04 -> 0x07 on schedule.
- **Parameter corners:**
  - SIZE=8, CHUNK=8: 0xFF + 0xFF, Cin=1 -> 0xFF, Cout=1, with PortDone 1 edge after the start edge.
  - SIZE=8, CHUNK=1: random 1000-vector add/sub sweep checked against a reference model, with PortDone at 8 edges.
